// File: rtl/uart_tx_sched_if.sv
// uart_tx_sched_if
// Purpose: bundles the two byte-requester handshakes that feed the UART
//          transmit scheduler.
// Signals:
//   req0_valid / req0_data / req0_ready : requester 0 handshake
//   req1_valid / req1_data / req1_ready : requester 1 handshake
// Modports:
//   master : the byte producers (drive valid/data, observe ready)
//   slave  : the scheduler (observes valid/data, drives ready)
interface uart_tx_sched_if #(
  parameter int WIDTH = 8
);
  logic             req0_valid;
  logic [WIDTH-1:0] req0_data;
  logic             req0_ready;
  logic             req1_valid;
  logic [WIDTH-1:0] req1_data;
  logic             req1_ready;

  modport master (
    output req0_valid, req0_data,
    input  req0_ready,
    output req1_valid, req1_data,
    input  req1_ready
  );

  modport slave (
    input  req0_valid, req0_data,
    output req0_ready,
    input  req1_valid, req1_data,
    output req1_ready
  );
endinterface

// File: rtl/uart_tx_sched.sv
// uart_tx_sched
// Purpose: transmit-side UART controller. Arbitrates round-robin between two
//          byte requesters, then frames the winning word as
//          start bit, WIDTH data bits LSB first, stop bit, each bit lasting
//          CLKS_PER_BIT clock cycles.
// Ports:
//   clk      : single clock, all state changes on its rising edge
//   reset    : synchronous, active-high
//   req      : requester handshakes (slave side of uart_tx_sched_if)
//   tx       : registered serial line, idles high
//   busy     : high while a frame is in flight
//   grant_id : requester whose word is being sent (held while idle)
//   tx_done  : one-cycle pulse on the last cycle of the stop bit
module uart_tx_sched #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             reset,
  uart_tx_sched_if.slave   req,
  output logic             tx,
  output logic             busy,
  output logic             grant_id,
  output logic             tx_done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] shifted;
  logic [CNT_W-1:0] baud_cnt;
  logic [CNT_W-1:0] baud_next;
  logic [IDX_W-1:0] bit_idx;
  logic [IDX_W-1:0] bit_next;
  logic             tx_next;
  logic             grant_next;
  logic             last_grant;
  logic             last_next;
  logic             sel;
  logic             bit_end;
  logic             accept;

  assign bit_end = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign shifted = shift_reg >> 1;

  // Arbiter choice: a lone requester wins outright; on a tie the one that
  // was not served last wins.
  always_comb begin
    sel = 1'b0;
    if (req.req0_valid && req.req1_valid) begin
      sel = ~last_grant;
    end else if (req.req1_valid) begin
      sel = 1'b1;
    end
  end

  assign req.req0_ready = (state == IDLE) && req.req0_valid && !sel;
  assign req.req1_ready = (state == IDLE) && req.req1_valid &&  sel;
  assign accept         = req.req0_ready || req.req1_ready;

  assign busy    = (state != IDLE);
  assign tx_done = (state == STOP) && bit_end;

  // Next-state and datapath logic. tx_next is the line value for the
  // following cycle, so tx changes on the same edge as the state.
  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    baud_next  = baud_cnt;
    bit_next   = bit_idx;
    tx_next    = tx;
    grant_next = grant_id;
    last_next  = last_grant;

    case (state)
      IDLE: begin
        tx_next = 1'b1;
        if (accept) begin
          state_next = START;
          shift_next = sel ? req.req1_data : req.req0_data;
          grant_next = sel;
          last_next  = sel;
          baud_next  = '0;
          bit_next   = '0;
          tx_next    = 1'b0;
        end
      end

      START: begin
        baud_next = bit_end ? '0 : baud_cnt + CNT_W'(1);
        if (bit_end) begin
          state_next = DATA;
          tx_next    = shift_reg[0];
        end
      end

      DATA: begin
        baud_next = bit_end ? '0 : baud_cnt + CNT_W'(1);
        if (bit_end) begin
          shift_next = shifted;
          bit_next   = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_W'(WIDTH - 1)) begin
            state_next = STOP;
            tx_next    = 1'b1;
          end else begin
            tx_next    = shifted[0];
          end
        end
      end

      STOP: begin
        baud_next = bit_end ? '0 : baud_cnt + CNT_W'(1);
        tx_next   = 1'b1;
        if (bit_end) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
        tx_next    = 1'b1;
      end
    endcase
  end

  // State register. Reset drops any frame in flight and makes requester 0
  // the winner of the next tie.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      tx         <= 1'b1;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      baud_cnt   <= baud_next;
      bit_idx    <= bit_next;
      tx         <= tx_next;
      grant_id   <= grant_next;
      last_grant <= last_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb_uart_tx_sched
// Purpose: self-checking bench for uart_tx_sched (WIDTH=8, CLKS_PER_BIT=4).
//          Words are queued per requester; a reference model predicts which
//          requester wins each arbitration and the exact serial waveform of
//          every frame as a list of bit values each held CLKS_PER_BIT cycles.
module tb_uart_tx_sched;

  localparam int WIDTH = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (WIDTH + 2) * CPB;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic busy;
  logic grant_id;
  logic tx_done;

  int checks = 0;
  int errors = 0;

  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  int model_last = 1;

  uart_tx_sched_if #(.WIDTH(WIDTH)) bus ();

  uart_tx_sched #(
    .WIDTH       (WIDTH),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (bus),
    .tx      (tx),
    .busy    (busy),
    .grant_id(grant_id),
    .tx_done (tx_done)
  );

  always #5 clk = ~clk;

  // One comparison: counted, then asserted.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Present each requester's queue head; an empty queue shows garbage data
  // with valid low.
  task automatic applyStimulus();
    bus.req0_valid = (q0.size() > 0);
    bus.req0_data  = (q0.size() > 0) ? q0[0] : WIDTH'($urandom);
    bus.req1_valid = (q1.size() > 0);
    bus.req1_data  = (q1.size() > 0) ? q1[0] : WIDTH'($urandom);
    #1;
  endtask

  function automatic int predictGrant();
    if (q0.size() > 0 && q1.size() > 0) return 1 - model_last;
    if (q0.size() > 0) return 0;
    return 1;
  endfunction

  // Frame line position p: 0 = start, 1..WIDTH = data LSB first, then stop.
  function automatic logic frameBit(input logic [WIDTH-1:0] word, input int p);
    if (p == 0) return 1'b0;
    if (p <= WIDTH) return word[p-1];
    return 1'b1;
  endfunction

  // Called in acceptance cycle A with inputs already driven; follows the
  // frame for ncycles cycles after A. Data inputs are scribbled every cycle
  // to show the in-flight word is unaffected.
  task automatic checkFrame(input int id, input logic [WIDTH-1:0] word,
                            input int ncycles);
    checkOutput("ready0_accept", bus.req0_ready, (id == 0));
    checkOutput("ready1_accept", bus.req1_ready, (id == 1));
    checkOutput("tx_idle_before", tx, 1);
    checkOutput("busy_idle_before", busy, 0);
    for (int c = 1; c <= ncycles; c++) begin
      nextCycle();
      bus.req0_data = WIDTH'($urandom);
      bus.req1_data = WIDTH'($urandom);
      #1;
      checkOutput("tx_bit", tx, frameBit(word, (c - 1) / CPB));
      checkOutput("busy_frame", busy, 1);
      checkOutput("tx_done", tx_done, (c == FRAME));
      checkOutput("grant_id", grant_id, id);
      checkOutput("ready0_busy", bus.req0_ready, 0);
      checkOutput("ready1_busy", bus.req1_ready, 0);
    end
  endtask

  // Serve every queued word; the model picks each winner and the bench
  // expects acceptance in the first idle cycle after the previous frame.
  task automatic runTraffic();
    int id;
    logic [WIDTH-1:0] word;
    while (q0.size() > 0 || q1.size() > 0) begin
      nextCycle();
      applyStimulus();
      id = predictGrant();
      word = (id == 0) ? q0.pop_front() : q1.pop_front();
      model_last = id;
      checkFrame(id, word, FRAME);
    end
    nextCycle();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;
    checkOutput("tx_idle_after", tx, 1);
    checkOutput("busy_idle_after", busy, 0);
    checkOutput("tx_done_idle", tx_done, 0);
  endtask

  task automatic doReset();
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    nextCycle();
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_tx_done", tx_done, 0);
    checkOutput("reset_grant_id", grant_id, 0);
    reset = 1'b0;
    model_last = 1;
    q0.delete();
    q1.delete();
  endtask

  initial begin
    logic [WIDTH-1:0] word;
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req0_data  = '0;
    bus.req1_data  = '0;
    nextCycle();
    doReset();

    // Single word from requester 0
    q0.push_back(8'hA5);
    runTraffic();

    // Tie straight after reset: requester 0 first, then requester 1
    doReset();
    q0.push_back(8'h11);
    q1.push_back(8'h22);
    runTraffic();

    // Data input changes during the frame
    doReset();
    q0.push_back(8'h0F);
    runTraffic();

    // Round robin with both requesters always valid
    doReset();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(WIDTH'($urandom));
      q1.push_back(WIDTH'($urandom));
    end
    runTraffic();

    // Single requester back-to-back
    doReset();
    for (int i = 0; i < 3; i++) q1.push_back(WIDTH'($urandom));
    runTraffic();

    // Random mixes without intermediate reset
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < $urandom_range(0, 3); i++) q0.push_back(WIDTH'($urandom));
      for (int i = 0; i < $urandom_range(0, 3); i++) q1.push_back(WIDTH'($urandom));
      runTraffic();
    end

    // Mid-frame reset during data bit 3 of a requester 0 frame
    doReset();
    q0.push_back(8'h3C);
    nextCycle();
    applyStimulus();
    word = q0.pop_front();
    checkFrame(0, word, 1 + 4 * CPB);
    reset = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    nextCycle();
    checkOutput("midreset_tx", tx, 1);
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_tx_done", tx_done, 0);
    reset = 1'b0;
    model_last = 1;
    nextCycle();
    checkOutput("midreset_not_resumed", busy, 0);
    checkOutput("midreset_tx_high", tx, 1);
    q0.push_back(WIDTH'($urandom));
    q1.push_back(WIDTH'($urandom));
    runTraffic();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
